// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the vector_scale block: field layout,
// encoding constants, sequencer states and small encoding helpers.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          FP_BIAS      = 127;
    localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF   = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed zero with the given sign.
    function automatic logic [31:0] fp_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

    // Signed infinity with the given sign.
    function automatic logic [31:0] fp_inf(input logic sign);
        return FP_POS_INF | {sign, 31'd0};
    endfunction

endpackage

// File: rtl/vector_scale_if.sv
// Upstream/downstream handshake bundle of vector_scale: scalar+direction
// input channel and the x/y/z result channel.
interface vector_scale_if;
    import fp32_pkg::*;

    logic        valid_in;
    logic [31:0] magnitude;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;
    logic        scale_ready;
    logic [31:0] vector_x;
    logic [31:0] vector_y;
    logic [31:0] vector_z;
    logic        valid_out;
    logic        vectors_ready;

    // Environment side: drives operands and downstream ready.
    modport master (
        output valid_in, magnitude, dir_x, dir_y, dir_z, vectors_ready,
        input  scale_ready, vector_x, vector_y, vector_z, valid_out
    );

    // Block side.
    modport slave (
        input  valid_in, magnitude, dir_x, dir_y, dir_z, vectors_ready,
        output scale_ready, vector_x, vector_y, vector_z, valid_out
    );
endinterface

// File: rtl/fp32_mul_core.sv
// Two-stage FP32 multiplier. Stage A (registered) decodes specials, forms
// the 24x24 mantissa product, exponent sum and sign. Stage B (combinational
// off the stage A registers) normalizes and rounds to nearest-even; the
// caller captures res_o on the edge where res_valid_o is high.
module fp32_mul_core
    import fp32_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        op_valid_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        res_valid_o,
    output logic [31:0] res_o
);

    localparam logic signed [9:0] BIAS10 = 10'(FP_BIAS);

    fp32_t a, b;
    assign a = op_a_i;
    assign b = op_b_i;

    // Denormals count as zero, so a zero exponent alone means zero.
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    assign a_nan  = (a.exp == FP_EXP_MAX) && (a.man != 23'd0);
    assign b_nan  = (b.exp == FP_EXP_MAX) && (b.man != 23'd0);
    assign a_inf  = (a.exp == FP_EXP_MAX) && (a.man == 23'd0);
    assign b_inf  = (b.exp == FP_EXP_MAX) && (b.man == 23'd0);
    assign a_zero = (a.exp == 8'd0);
    assign b_zero = (b.exp == 8'd0);

    logic              sign_d, sign_q;
    logic              special_d, special_q;
    logic [31:0]       special_val_d, special_val_q;
    logic [47:0]       prod_d, prod_q;
    logic signed [9:0] exp_d, exp_q;
    logic              valid_q;

    // Stage A: special-case decode, mantissa product and biased exponent sum.
    always_comb begin
        sign_d        = a.sign ^ b.sign;
        special_d     = 1'b1;
        special_val_d = FP_CANON_NAN;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            special_val_d = FP_CANON_NAN;
        end else if (a_inf || b_inf) begin
            special_val_d = fp_inf(sign_d);
        end else if (a_zero || b_zero) begin
            special_val_d = fp_zero(sign_d);
        end else begin
            special_d = 1'b0;
        end
        prod_d = {24'd0, 1'b1, a.man} * {24'd0, 1'b1, b.man};
        exp_d  = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - BIAS10;
    end

    // Stage A pipeline registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q       <= 1'b0;
            sign_q        <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 32'd0;
            prod_q        <= 48'd0;
            exp_q         <= 10'sd0;
        end else begin
            valid_q <= op_valid_i;
            if (op_valid_i) begin
                sign_q        <= sign_d;
                special_q     <= special_d;
                special_val_q <= special_val_d;
                prod_q        <= prod_d;
                exp_q         <= exp_d;
            end
        end
    end

    logic [22:0]       man_t, man_r;
    logic              guard, sticky, round_up;
    logic [24:0]       rnd;
    logic signed [9:0] exp_n, exp_r;

    // Stage B: normalize the product, round to nearest-even, clamp range.
    always_comb begin
        if (prod_q[47]) begin
            man_t  = prod_q[46:24];
            guard  = prod_q[23];
            sticky = |prod_q[22:0];
            exp_n  = exp_q + 10'sd1;
        end else begin
            man_t  = prod_q[45:23];
            guard  = prod_q[22];
            sticky = |prod_q[21:0];
            exp_n  = exp_q;
        end
        round_up = guard & (sticky | man_t[0]);
        rnd      = {2'b01, man_t} + {24'd0, round_up};
        // A carry out of rounding leaves an all-zero mantissa one binade up.
        if (rnd[24]) begin
            man_r = rnd[23:1];
            exp_r = exp_n + 10'sd1;
        end else begin
            man_r = rnd[22:0];
            exp_r = exp_n;
        end
        if (special_q) begin
            res_o = special_val_q;
        end else if (exp_r >= 10'sd255) begin
            res_o = fp_inf(sign_q);
        end else if (exp_r <= 10'sd0) begin
            res_o = fp_zero(sign_q);
        end else begin
            res_o = {sign_q, exp_r[7:0], man_r};
        end
    end

    assign res_valid_o = valid_q;

endmodule

// File: rtl/vector_scale.sv
// Scales an FP32 direction vector by an FP32 magnitude using one shared
// multiplier, issuing x, y, z in turn (two cycles each) and holding the
// three results until downstream accepts them.
module vector_scale
    import fp32_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_n_in,
    vector_scale_if.slave  bus
);

    state_e      state_q, state_d;
    logic [1:0]  comp_idx_q, comp_idx_d;
    logic        phase_q, phase_d;
    logic        load_en, op_valid, wr_en;

    logic [31:0] mag_q, dx_q, dy_q, dz_q;
    logic [31:0] vec_x_q, vec_y_q, vec_z_q;
    logic [31:0] op_dir;
    logic        res_valid;
    logic [31:0] res;

    // Sequencer: accept in IDLE, issue/collect one component per two cycles.
    always_comb begin
        state_d    = state_q;
        comp_idx_d = comp_idx_q;
        phase_d    = phase_q;
        load_en    = 1'b0;
        op_valid   = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    load_en    = 1'b1;
                    state_d    = MUL;
                    comp_idx_d = 2'd0;
                    phase_d    = 1'b0;
                end
            end
            MUL: begin
                if (!phase_q) begin
                    op_valid = 1'b1;
                    phase_d  = 1'b1;
                end else if (res_valid) begin
                    wr_en   = 1'b1;
                    phase_d = 1'b0;
                    if (comp_idx_q == 2'd2) begin
                        state_d = DONE;
                    end else begin
                        comp_idx_d = comp_idx_q + 2'd1;
                    end
                end
            end
            DONE: begin
                if (bus.vectors_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            comp_idx_q <= 2'd0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            comp_idx_q <= comp_idx_d;
            phase_q    <= phase_d;
        end
    end

    // Operand capture on input transfer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mag_q <= 32'd0;
            dx_q  <= 32'd0;
            dy_q  <= 32'd0;
            dz_q  <= 32'd0;
        end else if (load_en) begin
            mag_q <= bus.magnitude;
            dx_q  <= bus.dir_x;
            dy_q  <= bus.dir_y;
            dz_q  <= bus.dir_z;
        end
    end

    // Direction operand mux for the shared multiplier.
    always_comb begin
        case (comp_idx_q)
            2'd0:    op_dir = dx_q;
            2'd1:    op_dir = dy_q;
            default: op_dir = dz_q;
        endcase
    end

    fp32_mul_core u_mul (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .op_valid_i  (op_valid),
        .op_a_i      (mag_q),
        .op_b_i      (op_dir),
        .res_valid_o (res_valid),
        .res_o       (res)
    );

    // Result registers, written as each component leaves stage B.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vec_x_q <= 32'd0;
            vec_y_q <= 32'd0;
            vec_z_q <= 32'd0;
        end else if (wr_en) begin
            case (comp_idx_q)
                2'd0:    vec_x_q <= res;
                2'd1:    vec_y_q <= res;
                default: vec_z_q <= res;
            endcase
        end
    end

    assign bus.scale_ready = (state_q == IDLE);
    assign bus.valid_out   = (state_q == DONE);
    assign bus.vector_x    = vec_x_q;
    assign bus.vector_y    = vec_y_q;
    assign bus.vector_z    = vec_z_q;

endmodule

// File: tb/tb_vector_scale.sv
// Scoreboard bench for vector_scale: a driver pushes hand-computed expected
// vectors on issue, a negedge monitor pops and compares on each output
// transfer; directed checks cover reset, latency, backpressure and abort.
module tb_vector_scale;

    logic clk;
    logic rst_n;

    vector_scale_if vif ();

    vector_scale dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];

    typedef struct {
        logic [31:0] m, x, y, z, ex, ey, ez;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // Monitor: an output transfer happens on the next posedge when both are high.
    always @(negedge clk) begin
        if (rst_n && vif.valid_out && vif.vectors_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%08h_%08h_%08h required=none",
                         vif.vector_x, vif.vector_y, vif.vector_z);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("vec_x", vif.vector_x, e[95:64]);
                check("vec_y", vif.vector_y, e[63:32]);
                check("vec_z", vif.vector_z, e[31:0]);
                $display("xfer x=%08h y=%08h z=%08h", vif.vector_x, vif.vector_y, vif.vector_z);
            end
        end
    end

    // Drive one transaction and wait until it is accepted (edge E0).
    task automatic issue(input vec_t v, input bit push);
        int w;
        vif.magnitude = v.m;
        vif.dir_x     = v.x;
        vif.dir_y     = v.y;
        vif.dir_z     = v.z;
        vif.valid_in  = 1'b1;
        w = 0;
        while (!vif.scale_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!vif.scale_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        if (push) exp_q.push_back({v.ex, v.ey, v.ez});
        @(posedge clk); #1;
        vif.valid_in = 1'b0;
        $display("issue %s m=%08h d=%08h/%08h/%08h", v.name, v.m, v.x, v.y, v.z);
    endtask

    // Issue and measure edges from acceptance until valid_out.
    task automatic send(input vec_t v);
        int k;
        issue(v, 1'b1);
        k = 1;
        while (!vif.valid_out && k < 20) begin
            @(posedge clk); #1;
            if (!vif.valid_out) k++;
        end
        check({"latency_", v.name}, 32'(k), 32'd6);
    endtask

    initial begin
        vecs[0] = '{32'h40800000, 32'h3F000000, 32'hBF000000, 32'h3F400000,
                    32'h40000000, 32'hC0000000, 32'h40400000, "nominal"};
        vecs[1] = '{32'h41100000, 32'h3F800000, 32'h00000000, 32'h80000000,
                    32'h41100000, 32'h00000000, 32'h80000000, "axis"};
        vecs[2] = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 32'h00400000,
                    32'h7F800000, 32'h7F800000, 32'h00000000, "special1"};
        vecs[3] = '{32'h7F800000, 32'h00000000, 32'hC0000000, 32'h7FA00000,
                    32'h7FC00000, 32'hFF800000, 32'h7FC00000, "special2"};
        vecs[4] = '{32'hC0000000, 32'hBF800000, 32'h3FC00000, 32'h00000000,
                    32'h40000000, 32'hC0400000, 32'h80000000, "signs"};
        vecs[5] = '{32'h3FC00000, 32'h3F800001, 32'h3F800003, 32'h3FC00000,
                    32'h3FC00002, 32'h3FC00004, 32'h40100000, "round_tie"};
        vecs[6] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001,
                    32'h3F800002, 32'h3F800002, 32'h3F800002, "round_sticky"};
        vecs[7] = '{32'h3F000000, 32'h00800000, 32'h80800000, 32'h3F800001,
                    32'h00000000, 32'h80000000, 32'h3F000001, "underflow"};

        rst_n             = 1'b0;
        vif.valid_in      = 1'b0;
        vif.vectors_ready = 1'b1;
        vif.magnitude     = 32'd0;
        vif.dir_x         = 32'd0;
        vif.dir_y         = 32'd0;
        vif.dir_z         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scale_ready", 32'(vif.scale_ready), 32'd1);
        check("rst_valid_out", 32'(vif.valid_out), 32'd0);
        check("rst_vector_x", vif.vector_x, 32'd0);
        check("rst_vector_y", vif.vector_y, 32'd0);
        check("rst_vector_z", vif.vector_z, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) send(vecs[i]);

        // Backpressure: result must hold, no new acceptance while DONE.
        @(posedge clk); #1;
        vif.vectors_ready = 1'b0;
        send(vecs[0]);
        vif.valid_in  = 1'b1;
        vif.magnitude = 32'h40000000;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid_out", 32'(vif.valid_out), 32'd1);
            check("bp_scale_ready", 32'(vif.scale_ready), 32'd0);
            check("bp_hold_x", vif.vector_x, 32'h40000000);
            check("bp_hold_y", vif.vector_y, 32'hC0000000);
            check("bp_hold_z", vif.vector_z, 32'h40400000);
        end
        vif.valid_in      = 1'b0;
        vif.vectors_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid_out", 32'(vif.valid_out), 32'd0);
        check("bp_release_scale_ready", 32'(vif.scale_ready), 32'd1);

        // Reset in the middle of the nominal case, after x has been written.
        issue(vecs[0], 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_vector_x", vif.vector_x, 32'd0);
        check("abort_vector_y", vif.vector_y, 32'd0);
        check("abort_vector_z", vif.vector_z, 32'd0);
        check("abort_valid_out", 32'(vif.valid_out), 32'd0);
        check("abort_scale_ready", 32'(vif.scale_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(vecs[1]);
        send(vecs[0]);

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
